// File: rtl/sixteen_segment_decoder.sv
// fifo_sync: show-ahead FIFO with a count register; rd_dat reads as zero when empty.
// Latency: a write is visible on rd_* after the next edge when the FIFO was empty.
// Backpressure: wr is refused only when full and no read happens in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign rd_vld  = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = rd_vld && rd_rdy;
    assign do_push = wr_vld && (!full || do_pop);
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// sixteen_segment_decoder: rebuilds per-digit ASCII from a scanned 16-segment bus, queues changes.
// Latency: event on out_* after edge STABLE_CYCLES+1 of a pattern held from cycle 0 (FIFO empty).
// Backpressure: never stalls the display; a full FIFO drops the event and sets sticky overflow.
module sixteen_segment_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] segments,
    input  logic [2:0]  digit_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_digit,
    output logic [7:0]  out_char,
    output logic        out_err,
    output logic        frame_done,
    output logic        overflow
);
    localparam int CW     = $clog2(STABLE_CYCLES + 1);
    localparam int FONT_N = 15;

    // Ordered by ASCII; on a shared pattern ('5' / 'S') the earlier entry wins.
    localparam logic [15:0] FONT_SEG [FONT_N] = '{
        16'h0000, 16'h0030, 16'h00C0, 16'hFF09, 16'h3000,
        16'hEEC0, 16'hFCC0, 16'hDDC0, 16'hF3C0, 16'hCF80,
        16'h33C0, 16'h0F00, 16'hFF00, 16'hE3C0, 16'hDDC0
    };
    localparam logic [7:0] FONT_CHR [FONT_N] = '{
        8'h20, 8'h21, 8'h2D, 8'h30, 8'h31,
        8'h32, 8'h33, 8'h35, 8'h41, 8'h45,
        8'h48, 8'h4C, 8'h4F, 8'h50, 8'h53
    };

    typedef struct packed {
        logic [2:0] digit;
        logic [7:0] chr;
        logic       err;
    } ev_t;

    logic [15:0]           s1_seg;
    logic [2:0]            s1_dig;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  commit_q;
    logic                  commit;
    logic [7:0]            dec_char;
    logic                  dec_err;
    logic [7:0]            char_buf [8];
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_nxt;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    ev_t                   push_ev;
    ev_t                   head_ev;

    always_comb begin
        cnt_nxt = cnt;
        if ({segments, digit_sel} != {s1_seg, s1_dig})
            cnt_nxt = CW'(1);
        else if (cnt != CW'(STABLE_CYCLES))
            cnt_nxt = cnt + CW'(1);
    end

    always_comb begin
        dec_char = 8'h3F;
        dec_err  = 1'b1;
        for (int i = FONT_N - 1; i >= 0; i--) begin
            if (s1_seg == FONT_SEG[i]) begin
                dec_char = FONT_CHR[i];
                dec_err  = 1'b0;
            end
        end
    end

    assign commit   = commit_q && (int'(s1_dig) < NUM_DIGITS);
    assign seen_nxt = seen | (NUM_DIGITS'(1) << s1_dig);
    assign push     = commit && ((dec_char != char_buf[s1_dig]) || dec_err);
    assign pop      = out_valid && out_ready;
    assign push_ev  = '{digit: s1_dig, chr: dec_char, err: dec_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_seg     <= '0;
            s1_dig     <= '0;
            cnt        <= '0;
            commit_q   <= 1'b0;
            seen       <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < 8; i++)
                char_buf[i] <= 8'h00;
        end else begin
            s1_seg     <= segments;
            s1_dig     <= digit_sel;
            cnt        <= cnt_nxt;
            // Strobe only on the transition into the saturated count.
            commit_q   <= (cnt_nxt == CW'(STABLE_CYCLES)) && (cnt != CW'(STABLE_CYCLES));
            frame_done <= 1'b0;
            if (commit) begin
                if (&seen_nxt) begin
                    seen       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen_nxt;
                end
            end
            if (push)
                char_buf[s1_dig] <= dec_char;
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    fifo_sync #(
        .WIDTH ($bits(ev_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat (push_ev),
        .full   (fifo_full),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head_ev)
    );

    assign out_digit = head_ev.digit;
    assign out_char  = head_ev.chr;
    assign out_err   = head_ev.err;
endmodule

// File: tb/tb_sixteen_segment_decoder.sv
// Bench for sixteen_segment_decoder: font vectors plus scan, glitch, overflow and reset sequences,
// with a cycle-level scoreboard of expected FIFO events.
module tb_sixteen_segment_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] segments;
    logic [2:0]  digit_sel;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_digit;
    logic [7:0]  out_char;
    logic        out_err;
    logic        frame_done;
    logic        overflow;

    always #5 clk = ~clk;

    sixteen_segment_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .segments   (segments),
        .digit_sel  (digit_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digit  (out_digit),
        .out_char   (out_char),
        .out_err    (out_err),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct {
        logic [15:0] seg;
        logic [2:0]  dig;
        logic [7:0]  ch;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [2:0] dig;
        logic [7:0] ch;
        logic       err;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] m_buf [8];
    logic [5:0] m_seen;
    logic       m_ovf, m_frame, m_commit, m_err;
    logic [15:0] m_seg;
    logic [2:0] m_dig;
    logic [7:0] m_ch;
    int         m_run;
    int         checks = 0;
    int         failures = 0;
    int         n_pop = 0;
    int         n_frame = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) m_buf[i] = 8'h00;
        m_seen = '0; m_ovf = 1'b0; m_frame = 1'b0; m_commit = 1'b0;
        m_seg = '0; m_dig = '0; m_ch = '0; m_err = 1'b0; m_run = 0;
    endtask

    // Entered and left at a falling edge: check outputs, drive inputs, advance the model one edge.
    task automatic cycle(input logic [15:0] seg, input logic [2:0] dig, input logic [7:0] ch,
                         input logic e, input logic do_rst);
        int old_run;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("out_digit", 32'(out_digit), 32'(exp_q[0].dig));
            chk("out_char", 32'(out_char), 32'(exp_q[0].ch));
            chk("out_err", 32'(out_err), 32'(exp_q[0].err));
        end else begin
            chk("out_idle_zero", 32'({out_digit, out_char, out_err}), 32'd0);
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_done", 32'(frame_done), 32'(m_frame));
        if (out_valid && out_ready) n_pop++;
        if (frame_done) n_frame++;

        segments = seg; digit_sel = dig; rst = do_rst;
        if (do_rst) begin
            model_reset();
        end else begin
            m_frame = 1'b0;
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_commit && int'(m_dig) < 6) begin
                m_seen[m_dig] = 1'b1;
                if (&m_seen) begin
                    m_frame = 1'b1;
                    m_seen  = '0;
                end
                if (m_ch != m_buf[m_dig] || m_err) begin
                    m_buf[m_dig] = m_ch;
                    if (exp_q.size() < 8) exp_q.push_back({m_dig, m_ch, m_err});
                    else m_ovf = 1'b1;
                end
            end
            old_run = m_run;
            if (seg == m_seg && dig == m_dig) m_run = (m_run < 4) ? m_run + 1 : 4;
            else m_run = 1;
            m_commit = (m_run == 4) && (old_run != 4);
            m_seg = seg; m_dig = dig; m_ch = ch; m_err = e;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input vec_t v, input int n);
        repeat (n) cycle(v.seg, v.dig, v.ch, v.err, 1'b0);
    endtask

    task automatic do_reset(input vec_t v);
        cycle(v.seg, v.dig, v.ch, v.err, 1'b1);
    endtask

    vec_t tbl [19];
    vec_t hello [6];
    vec_t idle, glitch_a, glitch_b, v_a, v_p, v_1;
    int   base_pop, base_frame;

    initial begin
        tbl[0]  = '{16'h0000, 3'd0, 8'h20, 1'b0};
        tbl[1]  = '{16'h0030, 3'd1, 8'h21, 1'b0};
        tbl[2]  = '{16'h00C0, 3'd2, 8'h2D, 1'b0};
        tbl[3]  = '{16'hFF09, 3'd3, 8'h30, 1'b0};
        tbl[4]  = '{16'h3000, 3'd4, 8'h31, 1'b0};
        tbl[5]  = '{16'hEEC0, 3'd5, 8'h32, 1'b0};
        tbl[6]  = '{16'hFCC0, 3'd0, 8'h33, 1'b0};
        tbl[7]  = '{16'hDDC0, 3'd1, 8'h35, 1'b0};
        tbl[8]  = '{16'hF3C0, 3'd2, 8'h41, 1'b0};
        tbl[9]  = '{16'hCF80, 3'd3, 8'h45, 1'b0};
        tbl[10] = '{16'h33C0, 3'd4, 8'h48, 1'b0};
        tbl[11] = '{16'h0F00, 3'd5, 8'h4C, 1'b0};
        tbl[12] = '{16'hFF00, 3'd0, 8'h4F, 1'b0};
        tbl[13] = '{16'hE3C0, 3'd1, 8'h50, 1'b0};
        tbl[14] = '{16'h0F01, 3'd2, 8'h3F, 1'b1};
        tbl[15] = '{16'hFFFF, 3'd3, 8'h3F, 1'b1};
        tbl[16] = '{16'h33C0, 3'd6, 8'h48, 1'b0};
        tbl[17] = '{16'h0F01, 3'd2, 8'h3F, 1'b1};
        tbl[18] = '{16'hFF00, 3'd0, 8'h4F, 1'b0};
        hello[0] = '{16'h33C0, 3'd0, 8'h48, 1'b0};
        hello[1] = '{16'hCF80, 3'd1, 8'h45, 1'b0};
        hello[2] = '{16'h0F00, 3'd2, 8'h4C, 1'b0};
        hello[3] = '{16'h0F00, 3'd3, 8'h4C, 1'b0};
        hello[4] = '{16'hFF00, 3'd4, 8'h4F, 1'b0};
        hello[5] = '{16'h0030, 3'd5, 8'h21, 1'b0};
        idle     = '{16'h0000, 3'd7, 8'h20, 1'b0};
        glitch_a = '{16'h0F00, 3'd2, 8'h4C, 1'b0};
        glitch_b = '{16'h0F01, 3'd2, 8'h3F, 1'b1};
        v_a      = '{16'hF3C0, 3'd0, 8'h41, 1'b0};
        v_p      = '{16'hE3C0, 3'd1, 8'h50, 1'b0};
        v_1      = '{16'h3000, 3'd2, 8'h31, 1'b0};

        rst = 1'b1; out_ready = 1'b0; segments = '0; digit_sel = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Single stable character, consumer stalled
        hold(hello[0], 6);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_digit", 32'(out_digit), 32'd0);
        chk("t1_char", 32'(out_char), 32'h48);
        chk("t1_err", 32'(out_err), 32'd0);
        out_ready = 1'b1;
        hold(hello[0], 1);
        chk("t1_single_event", 32'(out_valid), 32'd0);

        // Font table
        do_reset(idle);
        for (int i = 0; i < 19; i++) hold(tbl[i], 6);
        hold(idle, 3);

        // HELLO! scanned twice
        do_reset(idle);
        base_pop = n_pop; base_frame = n_frame;
        for (int i = 0; i < 6; i++) hold(hello[i], 8);
        chk("t2_scan1_events", 32'(n_pop - base_pop), 32'd6);
        chk("t2_scan1_frames", 32'(n_frame - base_frame), 32'd1);
        base_pop = n_pop; base_frame = n_frame;
        for (int i = 0; i < 6; i++) hold(hello[i], 8);
        hold(idle, 2);
        chk("t2_scan2_events", 32'(n_pop - base_pop), 32'd0);
        chk("t2_scan2_frames", 32'(n_frame - base_frame), 32'd1);

        // Glitching digit never commits; then a held unknown pattern does
        do_reset(idle);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hold(glitch_b, 3);
            hold(glitch_a, 3);
        end
        chk("t3_no_glitch_event", 32'(out_valid), 32'd0);
        hold(glitch_b, 4);
        hold(idle, 1);
        chk("t3_err_valid", 32'(out_valid), 32'd1);
        chk("t3_err_char", 32'(out_char), 32'h3F);
        chk("t3_err_flag", 32'(out_err), 32'd1);
        out_ready = 1'b1;
        base_pop = n_pop;
        hold(idle, 3);
        chk("t3_one_event", 32'(n_pop - base_pop), 32'd1);

        // Nine changes into an eight-deep FIFO
        do_reset(idle);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) hold(hello[i], 5);
        hold(v_a, 5);
        hold(v_p, 5);
        chk("t4_no_ovf_at_8", 32'(overflow), 32'd0);
        hold(v_1, 5);
        chk("t4_ovf_at_9", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        base_pop = n_pop;
        hold(idle, 10);
        chk("t4_drain_count", 32'(n_pop - base_pop), 32'd8);

        // Full FIFO with a pop on the commit edge
        do_reset(idle);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) hold(hello[i], 5);
        hold(v_a, 5);
        hold(v_p, 5);
        hold(v_1, 4);
        out_ready = 1'b1;
        hold(v_1, 1);
        out_ready = 1'b0;
        hold(v_1, 2);
        chk("t5_no_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        base_pop = n_pop;
        hold(idle, 10);
        chk("t5_count_kept", 32'(n_pop - base_pop), 32'd8);

        // Reset with events queued and a partial stable run
        do_reset(idle);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) hold(hello[i], 5);
        hold(hello[3], 3);
        do_reset(hello[3]);
        chk("t6_valid_cleared", 32'(out_valid), 32'd0);
        chk("t6_ovf_cleared", 32'(overflow), 32'd0);
        hold(hello[3], 4);
        chk("t6_no_early_commit", 32'(out_valid), 32'd0);
        hold(hello[3], 1);
        chk("t6_commit_after_reset", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        hold(idle, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
